// File: rtl/cc_pkg.sv
// Shared definitions for the execute-stage condition-code logic.
//   - DATA_W      : width of the ALU result feeding the CC register
//   - C_*         : ifun encodings of the jXX/cmovXX conditions
//   - CC_RST      : reset value of {zf, sf, of}
//   - cc_from_result : derives the next {zf, sf, of} from an ALU result
package cc_pkg;

  localparam int DATA_W = 64;

  localparam logic [3:0] C_ALWAYS = 4'd0;
  localparam logic [3:0] C_LE     = 4'd1;
  localparam logic [3:0] C_L      = 4'd2;
  localparam logic [3:0] C_E      = 4'd3;
  localparam logic [3:0] C_NE     = 4'd4;
  localparam logic [3:0] C_GE     = 4'd5;
  localparam logic [3:0] C_G      = 4'd6;

  // {zf, sf, of}
  localparam logic [2:0] CC_RST = 3'b100;

  function automatic logic [2:0] cc_from_result(input logic signed [DATA_W-1:0] ans,
                                                input logic                     ovf);
    cc_from_result = {(ans == '0), ans[DATA_W-1], ovf};
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational condition evaluator for jXX/cmovXX.
//   ifun    in  4  condition encoding
//   zf/sf/of in 1  condition-code flags
//   cnd     out 1  condition outcome (0 for illegal ifun)
//   cnd_err out 1  ifun is not a legal condition
module cond_eval
  import cc_pkg::*;
(
  input  logic [3:0] ifun,
  input  logic       zf,
  input  logic       sf,
  input  logic       of,
  output logic       cnd,
  output logic       cnd_err
);

  logic lt;

  assign lt = sf ^ of;

  always_comb begin
    cnd     = 1'b0;
    cnd_err = 1'b0;
    case (ifun)
      C_ALWAYS: cnd = 1'b1;
      C_LE:     cnd = lt | zf;
      C_L:      cnd = lt;
      C_E:      cnd = zf;
      C_NE:     cnd = ~zf;
      C_GE:     cnd = ~lt;
      C_G:      cnd = ~lt & ~zf;
      default:  cnd_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/cc_cond_unit.sv
// Condition-code register plus condition query unit for the execute stage.
// Latches ZF/SF/OF from OPq-class results and answers condition queries
// through a one-entry registered output buffer with valid/ready handshake.
//   clk, rst           clock, synchronous active-high reset
//   res_valid, set_cc  result strobe / update-CC qualifier
//   alu_ans, alu_of    64-bit signed ALU result and overflow flag
//   cond_req/cond_ready/ifun   query request side (accept = req & ready)
//   cnd_valid/cnd_ready/cnd/cnd_err  result side
//   zf, sf, of         current CC register contents
module cc_cond_unit
  import cc_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     res_valid,
  input  logic                     set_cc,
  input  logic signed [DATA_W-1:0] alu_ans,
  input  logic                     alu_of,
  input  logic                     cond_req,
  output logic                     cond_ready,
  input  logic [3:0]               ifun,
  output logic                     cnd_valid,
  input  logic                     cnd_ready,
  output logic                     cnd,
  output logic                     cnd_err,
  output logic                     zf,
  output logic                     sf,
  output logic                     of
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_e;

  buf_state_e state;
  logic       accept;
  logic       cnd_p0;
  logic       cnd_err_p0;

  // Evaluated on the registered CC, so a same-cycle update is not bypassed.
  cond_eval u_eval (
    .ifun    (ifun),
    .zf      (zf),
    .sf      (sf),
    .of      (of),
    .cnd     (cnd_p0),
    .cnd_err (cnd_err_p0)
  );

  assign cnd_valid  = (state == FULL);
  assign cond_ready = ~cnd_valid | cnd_ready;
  assign accept     = cond_req & cond_ready;

  // Stage p0 -> p1: CC register and result buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      {zf, sf, of} <= CC_RST;
      state        <= EMPTY;
      cnd          <= 1'b0;
      cnd_err      <= 1'b0;
    end else begin
      if (res_valid && set_cc) begin
        {zf, sf, of} <= cc_from_result(alu_ans, alu_of);
      end
      case (state)
        EMPTY: begin
          if (accept) begin
            state   <= FULL;
            cnd     <= cnd_p0;
            cnd_err <= cnd_err_p0;
          end
        end
        FULL: begin
          // In FULL an accept implies cnd_ready: drain and reload together.
          if (accept) begin
            cnd     <= cnd_p0;
            cnd_err <= cnd_err_p0;
          end else if (cnd_ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule
